// File: rtl/ser32_5_pkg.sv
// ser32_5_pkg: shared widths, beat constants and FSM state type
// for the 32-to-5 word serializer (ser32_5, ser32_5_slice).
package ser32_5_pkg;

    localparam int WORD_W  = 32;
    localparam int SLICE_W = 5;
    localparam int BEATS   = 7;

    localparam logic [2:0] LAST_BEAT = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/ser32_5_slice.sv
// ser32_5_slice: picks beat `beat` of the latched word, zero-padding the
// 2-bit tail beat. Order set by SER32_5_MSB_FIRST_EN (default LSB-first).
// Ports: word (latched 32-bit word), beat (0..6), y (5-bit slice).
module ser32_5_slice
    import ser32_5_pkg::*;
(
    input  logic [WORD_W-1:0]  word,
    input  logic [2:0]         beat,
    output logic [SLICE_W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (beat)
`ifdef SER32_5_MSB_FIRST_EN
            3'd0: y = {3'b000, word[31:30]};
            3'd1: y = word[29:25];
            3'd2: y = word[24:20];
            3'd3: y = word[19:15];
            3'd4: y = word[14:10];
            3'd5: y = word[9:5];
            3'd6: y = word[4:0];
`else
            3'd0: y = word[4:0];
            3'd1: y = word[9:5];
            3'd2: y = word[14:10];
            3'd3: y = word[19:15];
            3'd4: y = word[24:20];
            3'd5: y = word[29:25];
            3'd6: y = {3'b000, word[31:30]};
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/ser32_5.sv
// ser32_5: accepts one 32-bit word (in_valid/in_ready) and emits it as
// seven 5-bit beats (out_valid/out_ready/Y), with last on beat 6.
// Ports: clk, reset (async, active-high), in_valid, in_ready, A,
// out_valid, out_ready, Y, last. Option: SER32_5_MSB_FIRST_EN.
module ser32_5
    import ser32_5_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  A,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] Y,
    output logic               last
);

    state_t             state_q, state_d;
    logic [2:0]         beat_q, beat_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [SLICE_W-1:0] slice_y;
    logic               at_last;
    logic               take;

    ser32_5_slice u_slice (
        .word (word_q),
        .beat (beat_q),
        .y    (slice_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        word_d    = word_q;
        out_valid = (state_q == SHIFT);
        at_last   = out_valid && (beat_q == LAST_BEAT);
        // Taking the next word while the last beat drains keeps the
        // output stream bubble-free.
        in_ready  = (state_q == IDLE) || (at_last && out_ready);
        take      = in_valid && in_ready;

        if (take) begin
            word_d  = A;
            beat_d  = '0;
            state_d = SHIFT;
        end else if (out_valid && out_ready) begin
            if (at_last) state_d = IDLE;
            else         beat_d  = beat_q + 3'd1;
        end
    end

    // Outputs come only from registered state; idle drives zeros.
    assign Y    = out_valid ? slice_y : '0;
    assign last = at_last;

endmodule

// File: tb/tb_ser32_5.sv
// tb_ser32_5: directed bench for ser32_5 with an expected-beat queue
// model compared every cycle, plus literal beat tables per scenario.
module tb_ser32_5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  Y;
    logic        last;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q[$];
    logic [4:0] got_y[$];
    logic       got_last[$];

    ser32_5 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .last      (last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Beat k of word a in output order, as a 5-bit slice.
    function automatic logic [4:0] beat_of(input logic [31:0] a,
                                           input int k);
        int j;
`ifdef SER32_5_MSB_FIRST_EN
        j = 6 - k;
`else
        j = k;
`endif
        beat_of = 5'((a >> (5 * j)) & 32'd31);
    endfunction

    always @(negedge clk) begin
        logic mv, mr;
        if (reset) begin
            exp_q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_Y", Y, 0);
            chk("rst_last", last, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            mv = (exp_q.size() != 0);
            mr = (exp_q.size() == 0) ||
                 (exp_q.size() == 1 && out_ready);
            chk("out_valid", out_valid, mv);
            chk("in_ready", in_ready, mr);
            if (mv) begin
                chk("Y", Y, exp_q[0][4:0]);
                chk("last", last, exp_q[0][5]);
            end
            if (mv && out_ready) begin
                got_y.push_back(Y);
                got_last.push_back(last);
                void'(exp_q.pop_front());
            end
            if (in_valid && mr)
                for (int k = 0; k < 7; k++)
                    exp_q.push_back({k == 6, beat_of(A, k)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_y.delete();
        got_last.delete();
    endtask

    task automatic check_log(input string nm, input logic [4:0] ex[$]);
        chk({nm, "_len"}, got_y.size(), ex.size());
        for (int i = 0; i < ex.size() && i < got_y.size(); i++) begin
            chk({nm, "_y"}, got_y[i], ex[i]);
            chk({nm, "_last"}, got_last[i], (i % 7) == 6);
        end
    endtask

    logic [4:0] t27[$], tff[$], t421[$];

    initial begin
`ifdef SER32_5_MSB_FIRST_EN
        t27  = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1B};
        tff  = '{5'h03, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
        t421 = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h01, 5'h01};
`else
        t27  = '{5'h1B, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        tff  = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h03};
        t421 = '{5'h01, 5'h01, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00};
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // Single word, continuous out_ready
        clear_log();
        in_valid = 1'b1; A = 32'd27; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check_log("basic27", t27);

        // Tail padding
        clear_log();
        in_valid = 1'b1; A = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check_log("pad", tff);

        // Backpressure at beat 1
        clear_log();
        in_valid = 1'b1; A = 32'h0000_0421;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (8) step();
        check_log("bp", t421);

        // Back-to-back words, in_valid held
        clear_log();
        in_valid = 1'b1; A = 32'd27;
        step();
        A = 32'hFFFF_FFFF;
        repeat (7) step();
        in_valid = 1'b0;
        repeat (9) step();
        check_log("b2b", {t27, tff});

        // Reset during beat 3
        clear_log();
        in_valid = 1'b1; A = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_Y", Y, 0);
        chk("midrst_last", last, 0);
        chk("midrst_in_ready", in_ready, 1);
        step();
        reset = 1'b0;
        step();
        clear_log();
        in_valid = 1'b1; A = 32'd27;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check_log("after_rst", t27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
